// File: rtl/stack_pointer_bank_pkg.sv
// Shared definitions for the stack pointer bank: command encodings,
// sticky fault bundle and region geometry helpers.
package stack_pkg;

    typedef enum logic [1:0] {
        SOP_NONE = 2'b00,
        SOP_PUSH = 2'b01,
        SOP_POP  = 2'b10,
        SOP_LOAD = 2'b11
    } stack_op_e;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic rng;
    } stack_flags_t;

    // Geometry is computed in 32 bits; callers keep the low WIDTH bits,
    // which gives the modulo-2^WIDTH wrap for regions at the address edges.
    function automatic logic [31:0] region_lo(input int unsigned idx,
                                              input int unsigned depth,
                                              input logic [31:0] base);
        return base + idx * depth;
    endfunction

    function automatic logic [31:0] region_empty_sp(input int unsigned idx,
                                                    input int unsigned depth,
                                                    input logic [31:0] base,
                                                    input bit grows_down);
        logic [31:0] lo;
        lo = region_lo(idx, depth, base);
        return grows_down ? lo + depth - 32'd1 : lo;
    endfunction

    function automatic logic [31:0] region_full_sp(input int unsigned idx,
                                                   input int unsigned depth,
                                                   input logic [31:0] base,
                                                   input bit grows_down);
        logic [31:0] lo;
        lo = region_lo(idx, depth, base);
        return grows_down ? lo - 32'd1 : lo + depth;
    endfunction

endpackage

// File: rtl/stack_pointer_bank_channel.sv
// One stack: pointer, occupancy count and sticky faults, updated when enabled.
module stack_pointer_channel
    import stack_pkg::*;
#(
    parameter int              WIDTH      = 16,
    parameter int              DEPTH      = 256,
    parameter int              CW         = 9,
    parameter logic [WIDTH-1:0] EMPTY_SP  = '0,
    parameter logic [WIDTH-1:0] FULL_SP   = '0,
    parameter bit              GROWS_DOWN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  stack_op_e        op,
    input  logic [WIDTH-1:0] load_val,
    input  logic             err_clr,
    input  logic             rng_ext,
    output logic [WIDTH-1:0] sp,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output stack_flags_t     flags
);

    // Load window is the span between the empty and full pointers, whichever
    // is numerically lower after wrapping.
    localparam logic [WIDTH-1:0] RANGE_LO  = (EMPTY_SP < FULL_SP) ? EMPTY_SP : FULL_SP;
    localparam logic [WIDTH-1:0] RANGE_HI  = (EMPTY_SP < FULL_SP) ? FULL_SP : EMPTY_SP;
    localparam logic [CW-1:0]    DEPTH_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] sp_nxt, sp_grow, sp_shrink, load_diff;
    logic [CW-1:0]    count_nxt;
    logic             in_range;
    stack_flags_t     new_flt, flags_nxt;

    assign full      = (count == DEPTH_CNT);
    assign empty     = (count == '0);
    assign sp_grow   = GROWS_DOWN ? sp - WIDTH'(1) : sp + WIDTH'(1);
    assign sp_shrink = GROWS_DOWN ? sp + WIDTH'(1) : sp - WIDTH'(1);
    assign in_range  = (load_val >= RANGE_LO) && (load_val <= RANGE_HI);
    assign load_diff = (load_val >= EMPTY_SP) ? load_val - EMPTY_SP : EMPTY_SP - load_val;

    // Next pointer/count and any fault raised by this cycle's command.
    always_comb begin
        sp_nxt    = sp;
        count_nxt = count;
        new_flt   = '0;
        if (en) begin
            unique case (op)
                SOP_PUSH: begin
                    if (full) new_flt.ovf = 1'b1;
                    else begin
                        sp_nxt    = sp_grow;
                        count_nxt = count + CW'(1);
                    end
                end
                SOP_POP: begin
                    if (empty) new_flt.unf = 1'b1;
                    else begin
                        sp_nxt    = sp_shrink;
                        count_nxt = count - CW'(1);
                    end
                end
                SOP_LOAD: begin
                    if (in_range) begin
                        sp_nxt    = load_val;
                        count_nxt = CW'(load_diff);
                    end else begin
                        new_flt.rng = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        new_flt.rng = new_flt.rng | rng_ext;
        // A fault raised this cycle survives a simultaneous clear.
        flags_nxt   = (err_clr ? stack_flags_t'('0) : flags) | new_flt;
    end

    // State register with synchronous reset to the empty stack.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp    <= EMPTY_SP;
            count <= '0;
            flags <= '0;
        end else begin
            sp    <= sp_nxt;
            count <= count_nxt;
            flags <= flags_nxt;
        end
    end

endmodule

// File: rtl/stack_pointer_bank.sv
// Bank of independent stack pointers: Sel decode, per-stack channels,
// address muxing toward memory, and flattened status outputs.
module stack_pointer_bank
    import stack_pkg::*;
#(
    parameter int               WIDTH      = 16,
    parameter int               NUM_STACKS = 2,
    parameter int               DEPTH      = 256,
    parameter logic [WIDTH-1:0] BASE_ADDR  = 16'hFE00,
    parameter bit               GROWS_DOWN = 1'b1,
    localparam int              SEL_W      = (NUM_STACKS > 1) ? $clog2(NUM_STACKS) : 1,
    localparam int              CW         = $clog2(DEPTH) + 1
) (
    input  logic                         CLK,
    input  logic                         CtrlRst_n,
    input  logic [SEL_W-1:0]             Sel,
    input  logic [1:0]                   Op,
    input  logic                         Write,
    input  logic [WIDTH-1:0]             LoadVal,
    input  logic                         ErrClr,
    output logic [WIDTH-1:0]             PushAddr,
    output logic [WIDTH-1:0]             TopAddr,
    output logic [NUM_STACKS*WIDTH-1:0]  SPOut,
    output logic [NUM_STACKS*CW-1:0]     CountOut,
    output logic [NUM_STACKS-1:0]        Full,
    output logic [NUM_STACKS-1:0]        Empty,
    output logic [NUM_STACKS-1:0]        Ovf,
    output logic [NUM_STACKS-1:0]        Unf,
    output logic [NUM_STACKS-1:0]        Rng,
    output logic                         Fault
);

    logic [NUM_STACKS-1:0][WIDTH-1:0] sp_arr;
    logic [NUM_STACKS-1:0][CW-1:0]    cnt_arr;
    stack_flags_t [NUM_STACKS-1:0]    flg_arr;
    logic [NUM_STACKS-1:0]            en;
    logic                             sel_ok;
    logic [SEL_W-1:0]                 sel_idx;

    // An out-of-range select is reported on stack 0's range flag.
    assign sel_ok  = (32'(Sel) < NUM_STACKS);
    assign sel_idx = sel_ok ? Sel : '0;

    for (genvar i = 0; i < NUM_STACKS; i++) begin : g_ch
        localparam logic [31:0] EMPTY32 = region_empty_sp(i, DEPTH, 32'(BASE_ADDR), GROWS_DOWN);
        localparam logic [31:0] FULL32  = region_full_sp(i, DEPTH, 32'(BASE_ADDR), GROWS_DOWN);

        assign en[i] = Write && sel_ok && (Sel == SEL_W'(i));

        stack_pointer_channel #(
            .WIDTH      (WIDTH),
            .DEPTH      (DEPTH),
            .CW         (CW),
            .EMPTY_SP   (EMPTY32[WIDTH-1:0]),
            .FULL_SP    (FULL32[WIDTH-1:0]),
            .GROWS_DOWN (GROWS_DOWN)
        ) u_ch (
            .clk      (CLK),
            .rst_n    (CtrlRst_n),
            .en       (en[i]),
            .op       (stack_op_e'(Op)),
            .load_val (LoadVal),
            .err_clr  (ErrClr),
            .rng_ext  ((i == 0) ? (Write && !sel_ok) : 1'b0),
            .sp       (sp_arr[i]),
            .count    (cnt_arr[i]),
            .full     (Full[i]),
            .empty    (Empty[i]),
            .flags    (flg_arr[i])
        );

        assign Ovf[i] = flg_arr[i].ovf;
        assign Unf[i] = flg_arr[i].unf;
        assign Rng[i] = flg_arr[i].rng;
    end

    assign SPOut    = sp_arr;
    assign CountOut = cnt_arr;

    // Zero-cycle Sel to address path; TopAddr is deliberately not gated when empty.
    always_comb begin
        PushAddr = sp_arr[sel_idx];
        TopAddr  = GROWS_DOWN ? PushAddr + WIDTH'(1) : PushAddr - WIDTH'(1);
    end

    assign Fault = |{Ovf, Unf, Rng};

endmodule

// File: tb/tb_stack_pointer_bank.sv
// Scoreboard bench: a down-growing and an up-growing bank share stimulus;
// a count-based reference model predicts state, a monitor compares it.
module tb_stack_pointer_bank;

    localparam int W = 16, N = 2, D = 4, CW = 3;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic          rst_n = 1'b0, wr = 1'b0, errclr = 1'b0;
    logic [0:0]    sel = '0;
    logic [1:0]    op = '0;
    logic [W-1:0]  lv = '0;

    logic [W-1:0]    push_d, top_d, push_u, top_u;
    logic [N*W-1:0]  spo_d, spo_u;
    logic [N*CW-1:0] cnt_d, cnt_u;
    logic [N-1:0]    full_d, empty_d, ovf_d, unf_d, rng_d;
    logic [N-1:0]    full_u, empty_u, ovf_u, unf_u, rng_u;
    logic            fault_d, fault_u;

    stack_pointer_bank #(.WIDTH(W), .NUM_STACKS(N), .DEPTH(D), .BASE_ADDR(16'h0100), .GROWS_DOWN(1'b1)) u_dn (
        .CLK(CLK), .CtrlRst_n(rst_n), .Sel(sel), .Op(op), .Write(wr), .LoadVal(lv), .ErrClr(errclr),
        .PushAddr(push_d), .TopAddr(top_d), .SPOut(spo_d), .CountOut(cnt_d), .Full(full_d), .Empty(empty_d),
        .Ovf(ovf_d), .Unf(unf_d), .Rng(rng_d), .Fault(fault_d));

    stack_pointer_bank #(.WIDTH(W), .NUM_STACKS(N), .DEPTH(D), .BASE_ADDR(16'h0100), .GROWS_DOWN(1'b0)) u_up (
        .CLK(CLK), .CtrlRst_n(rst_n), .Sel(sel), .Op(op), .Write(wr), .LoadVal(lv), .ErrClr(errclr),
        .PushAddr(push_u), .TopAddr(top_u), .SPOut(spo_u), .CountOut(cnt_u), .Full(full_u), .Empty(empty_u),
        .Ovf(ovf_u), .Unf(unf_u), .Rng(rng_u), .Fault(fault_u));

    typedef struct packed {
        logic [N-1:0][W-1:0]  sp;
        logic [N-1:0][CW-1:0] cnt;
        logic [N-1:0]         ovf, unf, rng;
    } st_t;

    st_t q_dn[$], q_up[$];
    int  checks = 0, errors = 0;

    // Reference model: per mode (0 = down, 1 = up) only occupancy and flags are
    // kept; the pointer is derived from the region edge and the occupancy.
    int         mcnt[2][N];
    logic [N-1:0] mo[2], mu[2], mr[2];

    function automatic logic [W-1:0] region_lo(int i);
        return W'(32'h0100 + i * D);
    endfunction

    function automatic logic [W-1:0] m_sp(int m, int i);
        if (m == 0) return W'(region_lo(i) + D - 1 - mcnt[m][i]);
        return W'(region_lo(i) + mcnt[m][i]);
    endfunction

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            logic [N-1:0] no, nu, nr;
            int s, lo, v;
            no = '0; nu = '0; nr = '0;
            s  = int'(sel);
            lo = int'(region_lo(s));
            v  = int'(lv);
            if (!rst_n) begin
                for (int i = 0; i < N; i++) mcnt[m][i] = 0;
                mo[m] = '0; mu[m] = '0; mr[m] = '0;
            end else begin
                if (wr) begin
                    case (op)
                        2'b01: if (mcnt[m][s] == D) no[s] = 1'b1; else mcnt[m][s]++;
                        2'b10: if (mcnt[m][s] == 0) nu[s] = 1'b1; else mcnt[m][s]--;
                        2'b11: begin
                            if (m == 0) begin
                                if (v >= lo - 1 && v <= lo + D - 1) mcnt[m][s] = lo + D - 1 - v;
                                else nr[s] = 1'b1;
                            end else begin
                                if (v >= lo && v <= lo + D) mcnt[m][s] = v - lo;
                                else nr[s] = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                mo[m] = (errclr ? '0 : mo[m]) | no;
                mu[m] = (errclr ? '0 : mu[m]) | nu;
                mr[m] = (errclr ? '0 : mr[m]) | nr;
            end
        end
    endtask

    function automatic st_t snap(int m);
        st_t e;
        for (int i = 0; i < N; i++) begin
            e.sp[i]  = m_sp(m, i);
            e.cnt[i] = CW'(mcnt[m][i]);
        end
        e.ovf = mo[m]; e.unf = mu[m]; e.rng = mr[m];
        return e;
    endfunction

    // Drive one command, let it take effect at the edge, then queue the prediction.
    task automatic step(input logic r, input logic w, input logic [1:0] o,
                        input logic [0:0] s, input logic [W-1:0] v, input logic ec);
        rst_n = r; wr = w; op = o; sel = s; lv = v; errclr = ec;
        @(posedge CLK);
        model_update();
        q_dn.push_back(snap(0));
        q_up.push_back(snap(1));
        #1;
    endtask

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_bank(input string tag, input st_t e, input bit down,
                              input logic [N*W-1:0] spo, input logic [N*CW-1:0] cnt,
                              input logic [N-1:0] full, empty, ovf, unf, rng, input logic fault,
                              input logic [W-1:0] push, top);
        logic [N-1:0] xf, xe;
        logic [W-1:0] xp;
        for (int i = 0; i < N; i++) begin
            xf[i] = (e.cnt[i] == CW'(D));
            xe[i] = (e.cnt[i] == '0);
        end
        xp = e.sp[sel];
        cmp({tag, ".sp"},    64'(spo),   64'(e.sp));
        cmp({tag, ".count"}, 64'(cnt),   64'(e.cnt));
        cmp({tag, ".full"},  64'(full),  64'(xf));
        cmp({tag, ".empty"}, 64'(empty), 64'(xe));
        cmp({tag, ".ovf"},   64'(ovf),   64'(e.ovf));
        cmp({tag, ".unf"},   64'(unf),   64'(e.unf));
        cmp({tag, ".rng"},   64'(rng),   64'(e.rng));
        cmp({tag, ".fault"}, 64'(fault), 64'(|{e.ovf, e.unf, e.rng}));
        cmp({tag, ".push"},  64'(push),  64'(xp));
        cmp({tag, ".top"},   64'(top),   64'(down ? xp + W'(1) : xp - W'(1)));
    endtask

    // Monitor: state is stable between edges, so compare on the falling edge.
    always @(negedge CLK) begin
        if (q_dn.size() > 0 && q_up.size() > 0) begin
            st_t ed, eu;
            ed = q_dn.pop_front();
            eu = q_up.pop_front();
            check_bank("dn", ed, 1'b1, spo_d, cnt_d, full_d, empty_d, ovf_d, unf_d, rng_d, fault_d, push_d, top_d);
            check_bank("up", eu, 1'b0, spo_u, cnt_u, full_u, empty_u, ovf_u, unf_u, rng_u, fault_u, push_u, top_u);
        end
    end

    initial begin
        // Reset, including a cycle where Write and ErrClr are also high.
        step(0, 0, 2'b00, 0, '0, 0);
        step(0, 1, 2'b01, 0, '0, 1);
        step(1, 0, 2'b00, 0, '0, 0);
        // Fill stack 0, then overflow it.
        repeat (5) step(1, 1, 2'b01, 0, '0, 0);
        // Underflow stack 1, then clear together with a push on it.
        step(1, 1, 2'b10, 1, '0, 0);
        step(1, 1, 2'b01, 1, '0, 1);
        // Loads: in range, out of range for down mode, boundary values.
        step(1, 1, 2'b11, 0, 16'h0101, 0);
        step(1, 1, 2'b11, 0, 16'h0104, 0);
        step(1, 1, 2'b11, 0, 16'h00FF, 0);
        step(1, 1, 2'b11, 0, 16'h0103, 0);
        step(1, 1, 2'b11, 0, 16'h0100, 0);
        // Re-raise overflow, then pop + clear, then clear with a new fault.
        repeat (5) step(1, 1, 2'b01, 0, '0, 0);
        step(1, 1, 2'b10, 0, '0, 1);
        step(1, 1, 2'b01, 0, '0, 0);
        step(1, 1, 2'b01, 0, '0, 1);
        step(1, 1, 2'b00, 0, '0, 1);
        // Alternating push/pop on stack 1 with a mid-sequence reset.
        for (int k = 0; k < 10; k++) begin
            if (k == 6) step(0, 1, 2'b01, 1, '0, 0);
            else step(1, 1, (k % 2 == 0) ? 2'b01 : 2'b10, 1, '0, 0);
        end
        // Write low: command ignored.
        step(1, 0, 2'b01, 0, '0, 0);
        // Randomized traffic with loads clustered around the region edges.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 7) != 0),
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 W'(16'h00FC + $urandom_range(0, 14)),
                 ($urandom_range(0, 7) == 0));
        end
        repeat (3) @(negedge CLK);
        cmp("queue_drained", 64'(q_dn.size() + q_up.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
